// File: rtl/pmipsl_dmem_responder.sv
// pmipsl_dmem_responder: data-memory responder for the MIPS-lite core.
// It holds a word RAM plus an IO page at FFF0-FFFF: OUT, IN, CYCLE, TCMP, STAT and WRCNT.
// Read data is combinational. Writes commit on the rising edge of clock.
// Optional macro PMIPSL_MISALIGN_ERR_EN flags odd-address accesses, suppresses
// the write and zeroes the read.
module pmipsl_dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int IN_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     dmemaddr,
    input  logic [15:0]     dmemwdata,
    input  logic            dmemwrite,
    input  logic            dmemread,
    output logic [15:0]     dmemrdata,
    input  logic [IN_W-1:0] inport,
    output logic [15:0]     outport,
    output logic            timer_flag,
    output logic            err
);
    logic [15:0] mem [1 << DEPTH_LOG2];
    logic [IN_W-1:0] sync1, sync2;
    logic [15:0] cycle, tcmp, wrcnt, io_rd, rd;
    logic is_io, mis, wr_ok, ram_we, w_out, w_cyc, w_tcmp, w_stat;
    logic [2:0] io_sel;
    logic [DEPTH_LOG2-1:0] idx;

    assign is_io  = dmemaddr[15:4] == 12'hFFF;
    assign io_sel = dmemaddr[3:1];
    assign idx    = dmemaddr[DEPTH_LOG2:1];
    // A write in a reset cycle is discarded everywhere.
    assign wr_ok  = dmemwrite & ~mis & ~reset;
    assign ram_we = wr_ok & ~is_io;
    assign w_out  = wr_ok & is_io & (io_sel == 3'd0);
    assign w_cyc  = wr_ok & is_io & (io_sel == 3'd2);
    assign w_tcmp = wr_ok & is_io & (io_sel == 3'd3);
    assign w_stat = wr_ok & is_io & (io_sel == 3'd4);

`ifdef PMIPSL_MISALIGN_ERR_EN
    assign mis = dmemaddr[0];
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) err <= 1'b0;
        else err <= err | (mis & (dmemread | dmemwrite));
    end
`else
    logic unused_addr_bit0;
    assign unused_addr_bit0 = dmemaddr[0];
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    // Read mux: old contents are returned, so a same-cycle write shows up one cycle later.
    always_comb begin
        io_rd = io_sel == 3'd0 ? outport :
                io_sel == 3'd1 ? 16'(sync2) :
                io_sel == 3'd2 ? cycle :
                io_sel == 3'd3 ? tcmp :
                io_sel == 3'd4 ? {15'b0, timer_flag} :
                io_sel == 3'd5 ? wrcnt : 16'h0000;
        rd = is_io ? io_rd : mem[idx];
        dmemrdata = (dmemread & ~mis) ? rd : 16'h0000;
    end

    // RAM is not reset, so its contents survive a reset.
    always_ff @(posedge clock) begin
        if (ram_we) mem[idx] <= dmemwdata;
    end

    // IO registers: the CYCLE write beats the increment, and a timer set beats a STAT clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            outport    <= 16'h0000;
            cycle      <= 16'h0000;
            tcmp       <= 16'h0000;
            timer_flag <= 1'b0;
            wrcnt      <= 16'h0000;
        end else begin
            sync1      <= inport;
            sync2      <= sync1;
            if (w_out) outport <= dmemwdata;
            if (w_tcmp) tcmp <= dmemwdata;
            cycle      <= w_cyc ? 16'h0000 : cycle + 16'd1;
            timer_flag <= (cycle == tcmp && tcmp != 16'h0000) ? 1'b1 : w_stat ? 1'b0 : timer_flag;
            wrcnt      <= wrcnt + 16'(ram_we && wrcnt != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_pmipsl_dmem_responder.sv
// tb_pmipsl_dmem_responder: scoreboard bench for the data-memory responder.
module tb_pmipsl_dmem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dmemaddr = '0, dmemwdata = '0, dmemrdata, outport;
    logic        dmemwrite = 1'b0, dmemread = 1'b0, timer_flag, err;
    logic [7:0]  inport = '0;
    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    pmipsl_dmem_responder #(.DEPTH_LOG2(6), .IN_W(8)) dut (
        .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
        .dmemwrite(dmemwrite), .dmemread(dmemread), .dmemrdata(dmemrdata),
        .inport(inport), .outport(outport), .timer_flag(timer_flag), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive just after the edge. When rd is set, push the expected read data.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp, input string tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
        dmemread = rd;
        dmemwrite = wr;
        dmemaddr = a;
        dmemwdata = wd;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "");
    endtask

    // Read data is combinational, so it is compared mid-cycle against the oldest expectation.
    always @(negedge clock) begin
        if (dmemread) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check(tag_q.pop_front(), {16'h0, dmemrdata}, {16'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_outport", outport, 16'h0000);
        check("rst_flag", timer_flag, 1'b0);
        check("rst_err", err, 1'b0);
        access(0, 1, 16'h0010, 16'h1234, 0, "");
        access(1, 0, 16'h0010, 0, 16'h1234, "ram_rd");
        access(1, 0, 16'hFFFA, 0, 16'h0001, "wrcnt1");
        access(0, 1, 16'h0090, 16'hBEEF, 0, "");
        access(1, 0, 16'h0010, 0, 16'hBEEF, "alias");
        access(1, 1, 16'h0010, 16'h5555, 16'hBEEF, "rw_old");
        access(1, 0, 16'h0010, 0, 16'h5555, "rw_new");
        access(1, 1, 16'hFFFA, 16'h9999, 16'h0003, "wrcnt3");
        access(1, 0, 16'hFFFA, 0, 16'h0003, "wrcnt_ro");
        access(0, 1, 16'hFFF0, 16'h00A5, 0, "");
        access(1, 0, 16'hFFF0, 0, 16'h00A5, "out_rd");
        @(negedge clock);
        check("outport", outport, 16'h00A5);
        access(1, 0, 16'hFFF2, 0, 16'h0000, "in_c0");
        inport = 8'h3C;
        access(1, 0, 16'hFFF2, 0, 16'h0000, "in_c1");
        access(1, 0, 16'hFFF2, 0, 16'h003C, "in_c2");
        access(0, 1, 16'hFFF4, 16'h1234, 0, "");
        access(0, 1, 16'hFFF6, 16'h0005, 0, "");
        access(1, 0, 16'hFFF4, 0, 16'h0001, "cycle1");
        access(1, 0, 16'hFFF6, 0, 16'h0005, "tcmp");
        access(1, 0, 16'hFFF8, 0, 16'h0000, "stat0");
        idle();
        @(negedge clock);
        check("flag_pre", timer_flag, 1'b0);
        access(0, 1, 16'hFFF8, 16'h0000, 0, "");
        access(1, 0, 16'hFFF8, 0, 16'h0001, "stat_set_prio");
        @(negedge clock);
        check("flag_set", timer_flag, 1'b1);
        access(0, 1, 16'hFFF8, 16'hFFFF, 0, "");
        access(1, 0, 16'hFFF8, 0, 16'h0000, "stat_clr");
        @(negedge clock);
        check("flag_clr", timer_flag, 1'b0);
        access(0, 1, 16'hFFF4, 16'hABCD, 0, "");
        access(1, 0, 16'hFFF4, 0, 16'h0000, "cycle_clr");
        access(1, 0, 16'hFFF4, 0, 16'h0001, "cycle_inc");
        access(1, 0, 16'hFFFC, 0, 16'h0000, "io_hole");
        access(0, 1, 16'h0010, 16'hDEAD, 0, "");
        reset = 1'b1;
        access(1, 0, 16'hFFF4, 0, 16'h0000, "rst_cycle0");
        access(1, 0, 16'hFFF4, 0, 16'h0001, "rst_cycle1");
        access(1, 0, 16'hFFFA, 0, 16'h0000, "rst_wrcnt");
        access(1, 0, 16'hFFF0, 0, 16'h0000, "rst_out_rd");
        access(1, 0, 16'h0010, 0, 16'h5555, "ram_keep");
        @(negedge clock);
        check("rst2_outport", outport, 16'h0000);
        check("rst2_flag", timer_flag, 1'b0);
        access(0, 1, 16'h0011, 16'h7777, 0, "");
`ifdef PMIPSL_MISALIGN_ERR_EN
        access(1, 0, 16'h0010, 0, 16'h5555, "mis_ram");
        access(1, 0, 16'hFFFA, 0, 16'h0000, "mis_wrcnt");
        access(1, 0, 16'h0011, 0, 16'h0000, "mis_rd");
        @(negedge clock);
        check("mis_err", err, 1'b1);
`else
        access(1, 0, 16'h0010, 0, 16'h7777, "mis_ram");
        access(1, 0, 16'hFFFA, 0, 16'h0001, "mis_wrcnt");
        access(1, 0, 16'h0011, 0, 16'h7777, "mis_rd");
        @(negedge clock);
        check("mis_err", err, 1'b0);
`endif
        idle();
        @(negedge clock);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
